dmem_arbiter: RTL and testbench

Arbiter sharing the single data-memory port between the CPU MEM stage and a DMA/loader requester. Sits between the EX_MEM memory-control outputs and DMEM. CPU accesses get priority. DMA is served in CPU-idle cycles, or by a forced, bounded burst that stalls the CPU once DMA has been starved. The memory path is a combinational mux; the ownership FSM, starvation and burst counters, and the DMA read-return register are sequential.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory port arbiter with starvation-forced DMA bursts.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 4,
    parameter logic [1:0]  SC_WORD      = 2'b00,
    parameter logic [2:0]  LC_WORD      = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_sc,
    input  logic [2:0]  cpu_lc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_sc,
    output logic [2:0]  mem_lc,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stat_cpu_stall,
    output logic [31:0] stat_dma_gnt
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

    typedef enum logic {
        S_CPU,
        S_DMA
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          gnt_raw, stall_raw;
    logic          dma_rd_gnt;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        burst_nxt  = burst_cnt;
        gnt_raw    = 1'b0;
        stall_raw  = 1'b0;
        case (state)
            S_DMA: begin
                // Starvation restarts from zero after every forced burst.
                starve_nxt = '0;
                if (dma_req) begin
                    gnt_raw   = 1'b1;
                    stall_raw = cpu_cs;
                    burst_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = S_CPU;
                    end
                end else begin
                    state_nxt = S_CPU;
                end
            end
            default: begin
                gnt_raw = dma_req & ~cpu_cs;
                if (dma_req & cpu_cs) begin
                    if (starve_cnt == STARVE_LAST) begin
                        state_nxt  = S_DMA;
                        starve_nxt = '0;
                        burst_nxt  = '0;
                    end else begin
                        starve_nxt = starve_cnt + 1'b1;
                    end
                end else begin
                    starve_nxt = '0;
                end
            end
        endcase
    end

    assign dma_gnt    = reset & gnt_raw;
    assign cpu_stall  = reset & stall_raw;
    assign dma_rd_gnt = dma_gnt & ~dma_we;
    assign cpu_rdata  = mem_rdata;

    // DMA ownership also masks any CPU store while the CPU is stalled.
    always_comb begin
        mem_cs    = cpu_cs;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_sc    = cpu_sc;
        mem_lc    = cpu_lc;
        if (dma_gnt) begin
            mem_cs    = 1'b1;
            mem_we    = dma_we;
            mem_re    = ~dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_sc    = SC_WORD;
            mem_lc    = LC_WORD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CPU;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
            dma_rvalid <= dma_rd_gnt;
            if (dma_rd_gnt) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_ctr, gnt_ctr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_ctr <= '0;
            gnt_ctr   <= '0;
        end else begin
            if (cpu_stall && stall_ctr != 32'hFFFF_FFFF) begin
                stall_ctr <= stall_ctr + 32'd1;
            end
            if (dma_gnt && gnt_ctr != 32'hFFFF_FFFF) begin
                gnt_ctr <= gnt_ctr + 32'd1;
            end
        end
    end

    assign stat_cpu_stall = stall_ctr;
    assign stat_dma_gnt   = gnt_ctr;
`else
    assign stat_cpu_stall = 32'd0;
    assign stat_dma_gnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cs, cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_sc;
    logic [2:0]  cpu_lc;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_cs, mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_sc;
    logic [2:0]  mem_lc;
    logic [31:0] stat_cpu_stall, stat_dma_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .MAX_BURST   (MAX_BURST),
        .SC_WORD     (2'b00),
        .LC_WORD     (3'b000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_cs        (cpu_cs),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_sc        (cpu_sc),
        .cpu_lc        (cpu_lc),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .mem_cs        (mem_cs),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_sc        (mem_sc),
        .mem_lc        (mem_lc),
        .mem_rdata     (mem_rdata),
        .stat_cpu_stall(stat_cpu_stall),
        .stat_dma_gnt  (stat_dma_gnt)
    );

    // Word-wide DMEM: combinational read, write at the clock edge.
    logic [31:0] dmem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_cs && mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = (mem_cs && mem_re) ? dmem[mem_addr[9:2]] : 32'h0;

    // Reference model: denied streak, remaining forced grants, expected memory image.
    int          m_denied;
    int          m_forced_left;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    logic        exp_gnt, exp_stall;

    task automatic model_reset();
        m_denied      = 0;
        m_forced_left = 0;
        m_rvalid      = 1'b0;
        m_rdata       = 32'h0;
    endtask

    task automatic model_eval();
        if (m_forced_left > 0 && dma_req) begin
            exp_gnt   = 1'b1;
            exp_stall = cpu_cs;
        end else begin
            exp_gnt   = dma_req && !cpu_cs;
            exp_stall = 1'b0;
        end
    endtask

    task automatic model_commit();
        logic [31:0] rd;
        model_eval();
        rd = ref_mem[dma_addr[9:2]];
        if (exp_gnt && dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
        else if (!exp_gnt && cpu_cs && cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        m_rvalid = exp_gnt && !dma_we;
        if (m_rvalid) m_rdata = rd;
        if (m_forced_left > 0) begin
            if (dma_req) m_forced_left = m_forced_left - 1;
            else m_forced_left = 0;
        end else if (dma_req && cpu_cs) begin
            m_denied = m_denied + 1;
            if (m_denied == STARVE_LIMIT) begin
                m_denied      = 0;
                m_forced_left = MAX_BURST;
            end
        end else begin
            m_denied = 0;
        end
    endtask

    task automatic tick();
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        cpu_cs = 0; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_sc = 0; cpu_lc = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        dma_req = 1; cpu_addr = 32'h44; cpu_sc = 2'b10;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt_stall: got gnt=%0b stall=%0b want 0 0", dma_gnt, cpu_stall);
        end
        n_tests++;
        if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got rvalid=%0b rdata=%h want 0 0", dma_rvalid, dma_rdata);
        end
        n_tests++;
        if (stat_cpu_stall !== 32'h0 || stat_dma_gnt !== 32'h0) begin
            n_fail++; $display("FAIL reset_stats: got %h %h want 0 0", stat_cpu_stall, stat_dma_gnt);
        end
        n_tests++;
        if (mem_addr !== 32'h44 || mem_cs !== 1'b0 || mem_sc !== 2'b10) begin
            n_fail++; $display("FAIL reset_mem_follow_cpu: got addr=%h cs=%0b sc=%0b want 44 0 10", mem_addr, mem_cs, mem_sc);
        end
        dma_req = 0;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_dma_rw();
        idle_inputs();
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hDEADBEEF;
        #1; model_eval();
        n_tests++;
        if (dma_gnt !== 1'b1 || dma_gnt !== exp_gnt || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dma_write: got gnt=%0b we=%0b addr=%h wdata=%h want 1 1 40 deadbeef", dma_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        dma_we = 0;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dma_read_issue: got gnt=%0b re=%0b we=%0b rd=%h want 1 1 0 deadbeef", dma_gnt, mem_re, mem_we, cpu_rdata);
        end
        tick();
        dma_req = 0;
        #1;
        n_tests++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dma_read_return: got rvalid=%0b rdata=%h want 1 deadbeef", dma_rvalid, dma_rdata);
        end
        tick();
        #1;
        n_tests++;
        if (dma_rvalid !== 1'b0 || dma_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dma_read_hold: got rvalid=%0b rdata=%h want 0 deadbeef", dma_rvalid, dma_rdata);
        end
    endtask

    task automatic test_starvation();
        logic g;
        idle_inputs();
        cpu_cs = 1; cpu_re = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hA5A5_5A5A;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            #1; model_eval();
            g = (i >= 4 && i < 8);
            n_tests++;
            if (dma_gnt !== g || cpu_stall !== g || dma_gnt !== exp_gnt || cpu_stall !== exp_stall) begin
                n_fail++; $display("FAIL starve_cycle%0d: got gnt=%0b stall=%0b want %0b %0b", i, dma_gnt, cpu_stall, g, g);
            end
            tick();
        end
        #1;
        n_tests++;
`ifdef DMEM_ARB_STATS_EN
        if (stat_dma_gnt !== 32'd4 || stat_cpu_stall !== 32'd4) begin
            n_fail++; $display("FAIL stats: got gnt=%0d stall=%0d want 4 4", stat_dma_gnt, stat_cpu_stall);
        end
`else
        if (stat_dma_gnt !== 32'd0 || stat_cpu_stall !== 32'd0) begin
            n_fail++; $display("FAIL stats: got gnt=%0d stall=%0d want 0 0", stat_dma_gnt, stat_cpu_stall);
        end
`endif
    endtask

    task automatic test_drop();
        idle_inputs();
        cpu_cs = 1; cpu_re = 1; cpu_addr = 32'h14;
        dma_req = 1; dma_addr = 32'h40;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if (dma_gnt !== (i >= 4) || cpu_stall !== (i >= 4)) begin
                n_fail++; $display("FAIL drop_cycle%0d: got gnt=%0b stall=%0b want %0b", i, dma_gnt, cpu_stall, i >= 4);
            end
            tick();
        end
        dma_req = 0;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 32'h14 || mem_re !== 1'b1) begin
            n_fail++; $display("FAIL drop_release: got gnt=%0b stall=%0b addr=%h want 0 0 14", dma_gnt, cpu_stall, mem_addr);
        end
        tick();
        dma_req = 1;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL drop_back_in_cpu: got gnt=%0b stall=%0b want 0 0", dma_gnt, cpu_stall);
        end
        tick();
    endtask

    task automatic test_cpu_store_stall();
        idle_inputs();
        cpu_cs = 1; cpu_re = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_addr = 32'h40;
        do_reset();
        repeat (4) begin
            #1; tick();
        end
        cpu_we = 1; cpu_re = 0; cpu_addr = 32'h80; cpu_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
                n_fail++; $display("FAIL store_masked%0d: got stall=%0b we=%0b addr=%h want 1 0 40", i, cpu_stall, mem_we, mem_addr);
            end
            tick();
        end
        #1;
        n_tests++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL store_released: got stall=%0b we=%0b addr=%h want 0 1 80", cpu_stall, mem_we, mem_addr);
        end
        tick();
        cpu_we = 0; cpu_re = 1; dma_req = 0;
        #1;
        n_tests++;
        if (cpu_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL store_readback: got %h want 12345678", cpu_rdata);
        end
        tick();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        cpu_cs = 1; cpu_re = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_addr = 32'h40;
        do_reset();
        repeat (6) begin
            #1; tick();
        end
        #1;
        n_tests++;
        if (dma_rvalid !== 1'b1 || dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got rvalid=%0b gnt=%0b stall=%0b want 1 1 1", dma_rvalid, dma_gnt, cpu_stall);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL areset_during: got gnt=%0b stall=%0b rvalid=%0b want 0 0 0", dma_gnt, cpu_stall, dma_rvalid);
        end
        model_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL areset_resume_cpu: got gnt=%0b stall=%0b want 0 0", dma_gnt, cpu_stall);
        end
        tick();
    endtask

    task automatic test_random();
        logic        e_cs, e_we, e_re;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [1:0]  e_sc;
        logic [2:0]  e_lc;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cpu_cs    = ($urandom_range(0, 1) == 1);
            cpu_we    = $urandom_range(0, 1);
            cpu_re    = $urandom_range(0, 1);
            cpu_addr  = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            cpu_wdata = $urandom;
            cpu_sc    = 2'($urandom_range(0, 3));
            cpu_lc    = 3'($urandom_range(0, 7));
            dma_req   = ($urandom_range(0, 9) < 6);
            dma_we    = $urandom_range(0, 1);
            dma_addr  = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            dma_wdata = $urandom;
            #1; model_eval();
            if (exp_gnt) begin
                e_cs = 1; e_we = dma_we; e_re = !dma_we; e_addr = dma_addr;
                e_wdata = dma_wdata; e_sc = 2'b00; e_lc = 3'b000;
            end else begin
                e_cs = cpu_cs; e_we = cpu_we; e_re = cpu_re; e_addr = cpu_addr;
                e_wdata = cpu_wdata; e_sc = cpu_sc; e_lc = cpu_lc;
            end
            e_rd = (e_cs && e_re) ? ref_mem[e_addr[9:2]] : 32'h0;
            n_tests++;
            if (dma_gnt !== exp_gnt || cpu_stall !== exp_stall || mem_cs !== e_cs || mem_we !== e_we
                || mem_re !== e_re || mem_addr !== e_addr || mem_wdata !== e_wdata || mem_sc !== e_sc
                || mem_lc !== e_lc || cpu_rdata !== e_rd || dma_rvalid !== m_rvalid || dma_rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got gnt=%0b stall=%0b we=%0b addr=%h rd=%h rv=%0b rdata=%h want %0b %0b %0b %h %h %0b %h",
                         i, dma_gnt, cpu_stall, mem_we, mem_addr, cpu_rdata, dma_rvalid, dma_rdata,
                         exp_gnt, exp_stall, e_we, e_addr, e_rd, m_rvalid, m_rdata);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_dma_rw();
        test_starvation();
        test_drop();
        test_cpu_store_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
